// File: rtl/neuron_accumulator.sv
// Q8.8 multiply-accumulate neuron: NUM_WORDS packed weight/input pairs -> saturated Q8.8 result.
// Optional ReLU activation when NEURON_ACC_RELU_EN is defined; linear pass-through otherwise.
//
// state  | meaning
// IDLE   | waiting for start, data_valid ignored
// ACCUM  | accepting valid words, stalls on data_valid == 0
// FINISH | one cycle: saturate, activate, pulse done
module neuron_accumulator #(
   parameter int NUM_WORDS = 4,
   parameter int ACC_W     = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   output logic        busy,
   output logic [15:0] result,
   output logic        done,
   output logic        overflow
);

   localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   // Q8.8 range limits expressed in Q16.16 accumulator units
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-23){1'b0}}, {23{1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-23){1'b1}}, {23{1'b0}}};

   logic [1:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_result;
   logic             r_done;
   logic             r_overflow;

   logic signed [31:0] w_prod;
   logic               w_sat_pos;
   logic               w_sat_neg;
   logic [15:0]        w_sat;
   logic [15:0]        w_act;

   assign w_prod    = $signed(data_in[31:16]) * $signed(data_in[15:0]);
   assign w_sat_pos = $signed(r_acc) > SAT_MAX;
   assign w_sat_neg = $signed(r_acc) < SAT_MIN;

   always_comb begin
      w_sat = r_acc[23:8];
      if (w_sat_pos)
         w_sat = 16'h7FFF;
      else if (w_sat_neg)
         w_sat = 16'h8000;
   end

`ifdef NEURON_ACC_RELU_EN
   assign w_act = w_sat[15] ? 16'h0000 : w_sat;
`else
   assign w_act = w_sat;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_result   <= 16'h0000;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= ACCUM;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_overflow <= 1'b0;
               end
            end
            ACCUM: begin
               if (data_valid) begin
                  r_acc <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT)
                     r_state <= FINISH;
               end
            end
            FINISH: begin
               r_result   <= w_act;
               r_overflow <= w_sat_pos | w_sat_neg;
               r_done     <= 1'b1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = (r_state != IDLE);
   assign result   = r_result;
   assign done     = r_done;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: reset, basic MAC, stalls, saturation, negative sum, back-to-back.
module tb_neuron_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] data_in;
   logic        data_valid;
   logic        busy;
   logic [15:0] result;
   logic        done;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   neuron_accumulator #(.NUM_WORDS(4), .ACC_W(40)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .data_in    (data_in),
      .data_valid (data_valid),
      .busy       (busy),
      .result     (result),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         data_in    = w;
         data_valid = 1'b1;
         tick();
      end
      data_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      checks++; if (result !== 16'h0000)  begin errors++; $display("FAIL reset_result got %h want 0000", result); end
   endtask

   task automatic test_basic();
      int d0;
      feed(32'h0100_0200, 2);          // ignored while idle
      d0 = done_cnt;
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
      feed(32'h0100_0200, 4);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %b want 0", done); end
      tick();
      checks++; if (done !== 1'b1)        begin errors++; $display("FAIL basic_done got %b want 1", done); end
      checks++; if (result !== 16'h0800)  begin errors++; $display("FAIL basic_result got %h want 0800", result); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL basic_ovf got %b want 0", overflow); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL basic_busy_drop got %b want 0", busy); end
      tick();
      checks++; if (done_cnt - d0 != 1)   begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_stall();
      logic [7:0] pat;
      int d0;
      pat = 8'b1110_1001;              // bit i applies to cycle i: 1,0,0,1,0,1,1,1
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         data_in    = 32'h0100_0200;
         data_valid = pat[i];
         start      = (i == 1);
         tick();
      end
      data_valid = 1'b0;
      start      = 1'b0;
      checks++; if (done !== 1'b1)       begin errors++; $display("FAIL stall_done got %b want 1", done); end
      checks++; if (result !== 16'h0800) begin errors++; $display("FAIL stall_result got %h want 0800", result); end
      for (int i = 0; i < 6; i++) tick();
      checks++; if (done_cnt - d0 != 1)  begin errors++; $display("FAIL stall_done_count got %0d want 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL stall_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_saturation_and_negative();
      logic [15:0] exp_neg;
      pulse_start();
      feed(32'h7FFF_7FFF, 4);
      tick();
      checks++; if (result !== 16'h7FFF) begin errors++; $display("FAIL possat_result got %h want 7fff", result); end
      checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL possat_ovf got %b want 1", overflow); end
      tick();
      pulse_start();
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
      feed(32'hFF00_0300, 4);
      tick();
`ifdef NEURON_ACC_RELU_EN
      exp_neg = 16'h0000;
`else
      exp_neg = 16'hF400;
`endif
      checks++; if (result !== exp_neg)  begin errors++; $display("FAIL neg_result got %h want %h", result, exp_neg); end
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL neg_ovf got %b want 0", overflow); end
      tick();
   endtask

   task automatic test_back_to_back();
      pulse_start();
      feed(32'h0100_0200, 4);
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
      feed(32'h0080_0100, 4);
      tick();
      checks++; if (done !== 1'b1)       begin errors++; $display("FAIL b2b_second_done got %b want 1", done); end
      checks++; if (result !== 16'h0200) begin errors++; $display("FAIL b2b_result got %h want 0200", result); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int d0;
      d0 = done_cnt;
      pulse_start();
      feed(32'h0100_0200, 2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL midrst_result got %h want 0000", result); end
      feed(32'h0100_0200, 2);
      for (int i = 0; i < 3; i++) tick();
      checks++; if (done_cnt - d0 != 0)  begin errors++; $display("FAIL midrst_no_done got %0d want 0", done_cnt - d0); end
      pulse_start();
      feed(32'h0100_0200, 4);
      tick();
      checks++; if (done !== 1'b1)       begin errors++; $display("FAIL midrst_rerun_done got %b want 1", done); end
      checks++; if (result !== 16'h0800) begin errors++; $display("FAIL midrst_rerun_result got %h want 0800", result); end
      tick();
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      data_in    = 32'h0;
      data_valid = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_saturation_and_negative();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
